// File: rtl/eth_frame_loop_pkg.sv
// Shared definitions for the frame loop: checksum word layout, stream
// widths and the FSM state encoding used by both loop halves.
package eth_frame_loop_pkg;

    localparam int FRAME_W        = 8;
    localparam int CSUM_W         = 32;
    localparam int CSUM_VALID_BIT = 0;
    localparam int CSUM_POS_MSB   = 15;
    localparam int CSUM_VALUE_LSB = 16;
    localparam int STATE_W        = 1;

    // Checksum FIFO word: recomputed value, even byte offset (bit 0 implied
    // zero) and a flag telling the transmitter whether to patch at all.
    typedef struct packed {
        logic [15:0] value;
        logic [14:0] pos_hi;
        logic        valid;
    } csum_word_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 1'b0,
        ST_TX   = 1'b1
    } state_t;

endpackage

// File: rtl/eth_frame_loop_tx_if.sv
// Stream bundle between the loop FIFOs, the transmitter and the MAC.
// slave is the transmitter's view; master is the environment's view.
interface eth_frame_loop_tx_if;
    import eth_frame_loop_pkg::*;

    logic [FRAME_W-1:0] s_axis_frame_tdata;
    logic               s_axis_frame_tuser;
    logic               s_axis_frame_tlast;
    logic               s_axis_frame_tvalid;
    logic               s_axis_frame_tready;

    logic [CSUM_W-1:0]  s_axis_csum_tdata;
    logic               s_axis_csum_tvalid;
    logic               s_axis_csum_tready;

    logic [FRAME_W-1:0] m_axis_tdata;
    logic               m_axis_tuser;
    logic               m_axis_tlast;
    logic               m_axis_tvalid;
    logic               m_axis_tready;

    modport slave (
        input  s_axis_frame_tdata, s_axis_frame_tuser, s_axis_frame_tlast,
        input  s_axis_frame_tvalid,
        output s_axis_frame_tready,
        input  s_axis_csum_tdata, s_axis_csum_tvalid,
        output s_axis_csum_tready,
        output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_frame_tdata, s_axis_frame_tuser, s_axis_frame_tlast,
        output s_axis_frame_tvalid,
        input  s_axis_frame_tready,
        output s_axis_csum_tdata, s_axis_csum_tvalid,
        input  s_axis_csum_tready,
        input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );

endinterface

// File: rtl/eth_frame_loop_tx.sv
// Frame loop transmitter: pops one checksum word per frame, then streams the
// frame bytes to the MAC, overwriting the two checksum bytes when flagged.
module eth_frame_loop_tx
    import eth_frame_loop_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int POS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eth_frame_loop_tx_if.slave   bus,
    output logic [CNT_WIDTH-1:0] stat_frames_tx,
    output logic [CNT_WIDTH-1:0] stat_frames_err
);

    state_t                 state_q, state_d;
    csum_word_t             csum_q, csum_d;
    logic [POS_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic                   err_seen_q, err_seen_d;
    logic [CNT_WIDTH-1:0]   stat_tx_q, stat_tx_d;
    logic [CNT_WIDTH-1:0]   stat_err_q, stat_err_d;

    logic                   beat_s;
    logic                   csum_valid_s;
    logic [POS_WIDTH-1:0]   pos_hi_byte_s;
    logic [POS_WIDTH-1:0]   pos_lo_byte_s;

    // Patch offsets are even, so the low-byte offset is just bit 0 set.
    assign csum_valid_s  = csum_q[CSUM_VALID_BIT];
    assign pos_hi_byte_s = {csum_q[CSUM_POS_MSB:1], 1'b0};
    assign pos_lo_byte_s = {csum_q[CSUM_POS_MSB:1], 1'b1};
    assign beat_s        = (state_q == ST_TX) && bus.s_axis_frame_tvalid && bus.m_axis_tready;

    assign stat_frames_tx  = stat_tx_q;
    assign stat_frames_err = stat_err_q;

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            csum_q     <= '0;
            byte_cnt_q <= '0;
            err_seen_q <= 1'b0;
            stat_tx_q  <= '0;
            stat_err_q <= '0;
        end else begin
            state_q    <= state_d;
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_d;
            err_seen_q <= err_seen_d;
            stat_tx_q  <= stat_tx_d;
            stat_err_q <= stat_err_d;
        end
    end

    // Next state: pop a checksum word to open a frame, count beats, close on tlast.
    always_comb begin
        state_d    = state_q;
        csum_d     = csum_q;
        byte_cnt_d = byte_cnt_q;
        err_seen_d = err_seen_q;
        stat_tx_d  = stat_tx_q;
        stat_err_d = stat_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.s_axis_csum_tvalid) begin
                    csum_d     = bus.s_axis_csum_tdata;
                    byte_cnt_d = '0;
                    err_seen_d = 1'b0;
                    state_d    = ST_TX;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TX: begin
                if (beat_s) begin
                    if (byte_cnt_q != {POS_WIDTH{1'b1}}) begin
                        byte_cnt_d = byte_cnt_q + {{(POS_WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        byte_cnt_d = byte_cnt_q;
                    end
                    err_seen_d = err_seen_q | bus.s_axis_frame_tuser;
                    if (bus.s_axis_frame_tlast) begin
                        stat_tx_d = stat_tx_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        if (err_seen_q || bus.s_axis_frame_tuser) begin
                            stat_err_d = stat_err_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            stat_err_d = stat_err_q;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_TX;
                    end
                end else begin
                    state_d = ST_TX;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: idle pops the checksum FIFO, TX passes bytes through with patching.
    always_comb begin
        bus.s_axis_csum_tready  = 1'b0;
        bus.s_axis_frame_tready = 1'b0;
        bus.m_axis_tvalid       = 1'b0;
        bus.m_axis_tdata        = 8'h00;
        bus.m_axis_tuser        = 1'b0;
        bus.m_axis_tlast        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.s_axis_csum_tready = bus.s_axis_csum_tvalid;
            end
            ST_TX: begin
                bus.m_axis_tvalid       = bus.s_axis_frame_tvalid;
                bus.s_axis_frame_tready = bus.m_axis_tready;
                bus.m_axis_tuser        = bus.s_axis_frame_tuser;
                bus.m_axis_tlast        = bus.s_axis_frame_tlast;
                if (csum_valid_s && (byte_cnt_q == pos_hi_byte_s)) begin
                    bus.m_axis_tdata = csum_q[CSUM_VALUE_LSB+8 +: 8];
                end else if (csum_valid_s && (byte_cnt_q == pos_lo_byte_s)) begin
                    bus.m_axis_tdata = csum_q[CSUM_VALUE_LSB +: 8];
                end else begin
                    bus.m_axis_tdata = bus.s_axis_frame_tdata;
                end
            end
            default: begin
                bus.s_axis_csum_tready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_eth_frame_loop_tx.sv
// Directed bench for the frame loop transmitter.
module tb_eth_frame_loop_tx;
    import eth_frame_loop_pkg::*;

    logic clk;
    logic rst_n;
    logic [31:0] stat_frames_tx;
    logic [31:0] stat_frames_err;

    eth_frame_loop_tx_if b ();

    eth_frame_loop_tx #(.CNT_WIDTH(32), .POS_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (b),
        .stat_frames_tx  (stat_frames_tx),
        .stat_frames_err (stat_frames_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // source frame and captured output
    logic [7:0] in_data [0:127];
    logic       in_user [0:127];
    logic       in_last [0:127];
    logic [7:0] out_data [0:127];
    logic       out_user [0:127];
    logic       out_last [0:127];
    int out_n, stall_viol, pop_cnt, pre_valid_viol, pop_cyc, first_cyc;
    bit timed_out;

    task automatic fill(input int n, input int base, input int step);
        for (int i = 0; i < 128; i++) begin
            in_data[i] = 8'((base + i * step) & 255);
            in_user[i] = 1'b0;
            in_last[i] = (i == n - 1);
        end
    endtask

    task automatic run_frame(input int n, input logic [31:0] cw, input int csum_delay, input bit rnd);
        int idx;
        bit popped, done, hold, gap;
        logic [7:0] p_data;
        logic p_user, p_last;
        idx = 0; popped = 0; done = 0; hold = 0; gap = 0;
        p_data = 8'h00; p_user = 1'b0; p_last = 1'b0;
        out_n = 0; stall_viol = 0; pop_cnt = 0; pre_valid_viol = 0;
        pop_cyc = -1; first_cyc = -1;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            b.s_axis_csum_tvalid = !popped && (c >= csum_delay);
            b.s_axis_csum_tdata  = cw;
            if (!hold) gap = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            b.s_axis_frame_tvalid = (idx < n) && !gap;
            b.s_axis_frame_tdata  = in_data[idx];
            b.s_axis_frame_tuser  = in_user[idx];
            b.s_axis_frame_tlast  = in_last[idx];
            b.m_axis_tready       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (hold && (!b.m_axis_tvalid || b.m_axis_tdata !== p_data ||
                         b.m_axis_tuser !== p_user || b.m_axis_tlast !== p_last))
                stall_viol++;
            if (!popped && b.m_axis_tvalid) pre_valid_viol++;
            if (b.s_axis_csum_tready) begin
                pop_cnt++;
                pop_cyc = c;
                if (b.s_axis_csum_tvalid) popped = 1;
            end
            if (b.m_axis_tvalid && b.m_axis_tready) begin
                if (first_cyc < 0) first_cyc = c;
                if (out_n < 128) begin
                    out_data[out_n] = b.m_axis_tdata;
                    out_user[out_n] = b.m_axis_tuser;
                    out_last[out_n] = b.m_axis_tlast;
                end
                out_n++;
                if (b.m_axis_tlast) done = 1;
            end
            if (b.s_axis_frame_tvalid && b.s_axis_frame_tready) idx++;
            hold   = b.m_axis_tvalid && !b.m_axis_tready;
            p_data = b.m_axis_tdata;
            p_user = b.m_axis_tuser;
            p_last = b.m_axis_tlast;
        end
        timed_out = !done;
        @(posedge clk);
        #1;
        b.s_axis_frame_tvalid = 1'b0;
        b.s_axis_csum_tvalid  = 1'b0;
        b.m_axis_tready       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b.s_axis_frame_tvalid = 1'b0; b.s_axis_frame_tdata = 8'h00;
        b.s_axis_frame_tuser = 1'b0;  b.s_axis_frame_tlast = 1'b0;
        b.s_axis_csum_tvalid = 1'b0;  b.s_axis_csum_tdata = 32'h0;
        b.m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (b.m_axis_tvalid !== 1'b0) $display("FAIL reset_m_tvalid got %b want 0", b.m_axis_tvalid); else n_pass++;
        n_total++;
        if (b.s_axis_frame_tready !== 1'b0) $display("FAIL reset_frame_tready got %b want 0", b.s_axis_frame_tready); else n_pass++;
        n_total++;
        if (b.s_axis_csum_tready !== 1'b0) $display("FAIL reset_csum_tready got %b want 0", b.s_axis_csum_tready); else n_pass++;
        n_total++;
        if (stat_frames_tx !== 32'd0) $display("FAIL reset_stat_tx got %0d want 0", stat_frames_tx); else n_pass++;
        n_total++;
        if (stat_frames_err !== 32'd0) $display("FAIL reset_stat_err got %0d want 0", stat_frames_err); else n_pass++;
        n_total++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_mode1_frame(input string tag);
        int bad;
        logic [7:0] exp;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            exp = (i == 40) ? 8'hAB : (i == 41) ? 8'hCD : 8'(i);
            if (out_data[i] !== exp || out_user[i] !== 1'b0 || out_last[i] !== (i == 63)) bad++;
        end
        if (timed_out !== 1'b0) $display("FAIL %s_timeout got %b want 0", tag, timed_out); else n_pass++;
        n_total++;
        if (out_n !== 64) $display("FAIL %s_len got %0d want 64", tag, out_n); else n_pass++;
        n_total++;
        if (bad !== 0) $display("FAIL %s_bytes got %0d bad want 0", tag, bad); else n_pass++;
        n_total++;
        if (out_data[40] !== 8'hAB) $display("FAIL %s_byte40 got %h want ab", tag, out_data[40]); else n_pass++;
        n_total++;
        if (out_data[41] !== 8'hCD) $display("FAIL %s_byte41 got %h want cd", tag, out_data[41]); else n_pass++;
        n_total++;
    endtask

    task automatic test_mode1();
        fill(64, 0, 1);
        run_frame(64, 32'hABCD_0029, 0, 1'b0);
        check_mode1_frame("mode1");
        if (first_cyc !== pop_cyc + 1) $display("FAIL mode1_latency got %0d want %0d", first_cyc, pop_cyc + 1); else n_pass++;
        n_total++;
        if (stat_frames_tx !== 32'd1) $display("FAIL mode1_stat_tx got %0d want 1", stat_frames_tx); else n_pass++;
        n_total++;
    endtask

    task automatic test_mode0();
        int bad;
        fill(60, 1, 3);
        run_frame(60, 32'h0000_0000, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 60; i++)
            if (out_data[i] !== 8'(((1 + 3 * i) & 255)) || out_last[i] !== (i == 59)) bad++;
        if (timed_out !== 1'b0 || out_n !== 60) $display("FAIL mode0_len got %0d want 60", out_n); else n_pass++;
        n_total++;
        if (bad !== 0) $display("FAIL mode0_bytes got %0d bad want 0", bad); else n_pass++;
        n_total++;
        if (stat_frames_tx !== 32'd2) $display("FAIL mode0_stat_tx got %0d want 2", stat_frames_tx); else n_pass++;
        n_total++;
        if (stat_frames_err !== 32'd0) $display("FAIL mode0_stat_err got %0d want 0", stat_frames_err); else n_pass++;
        n_total++;
    endtask

    task automatic test_csum_wait();
        int bad;
        fill(16, 8'h80, 1);
        run_frame(16, 32'h0000_0000, 20, 1'b0);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (out_data[i] !== 8'(8'h80 + i)) bad++;
        if (pre_valid_viol !== 0) $display("FAIL wait_no_valid got %0d want 0", pre_valid_viol); else n_pass++;
        n_total++;
        if (pop_cnt !== 1) $display("FAIL wait_pop_pulses got %0d want 1", pop_cnt); else n_pass++;
        n_total++;
        if (pop_cyc !== 20) $display("FAIL wait_pop_cycle got %0d want 20", pop_cyc); else n_pass++;
        n_total++;
        if (first_cyc !== 21) $display("FAIL wait_first_beat got %0d want 21", first_cyc); else n_pass++;
        n_total++;
        if (timed_out !== 1'b0 || out_n !== 16 || bad !== 0) $display("FAIL wait_frame got %0d bytes %0d bad want 16 0", out_n, bad); else n_pass++;
        n_total++;
    endtask

    task automatic test_stall();
        fill(64, 0, 1);
        run_frame(64, 32'hABCD_0029, 3, 1'b1);
        check_mode1_frame("stall");
        if (stall_viol !== 0) $display("FAIL stall_stable got %0d want 0", stall_viol); else n_pass++;
        n_total++;
        if (stat_frames_tx !== 32'd4) $display("FAIL stall_stat_tx got %0d want 4", stat_frames_tx); else n_pass++;
        n_total++;
    endtask

    task automatic test_truncated();
        int bad;
        fill(11, 8'h10, 1);
        in_data[10] = 8'h00; in_user[10] = 1'b1; in_last[10] = 1'b1;
        run_frame(11, 32'h0000_0000, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++)
            if (out_data[i] !== 8'(8'h10 + i) || out_user[i] !== 1'b0 || out_last[i] !== 1'b0) bad++;
        if (timed_out !== 1'b0 || out_n !== 11) $display("FAIL trunc_len got %0d want 11", out_n); else n_pass++;
        n_total++;
        if (bad !== 0) $display("FAIL trunc_body got %0d bad want 0", bad); else n_pass++;
        n_total++;
        if (out_user[10] !== 1'b1 || out_last[10] !== 1'b1 || out_data[10] !== 8'h00)
            $display("FAIL trunc_term got %h/%b/%b want 00/1/1", out_data[10], out_user[10], out_last[10]);
        else n_pass++;
        n_total++;
        if (stat_frames_err !== 32'd1) $display("FAIL trunc_stat_err got %0d want 1", stat_frames_err); else n_pass++;
        n_total++;
        // following clean frame
        fill(8, 8'h40, 2);
        run_frame(8, 32'h0000_0000, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (out_data[i] !== 8'(8'h40 + 2 * i) || out_user[i] !== 1'b0) bad++;
        if (timed_out !== 1'b0 || out_n !== 8 || bad !== 0) $display("FAIL clean_frame got %0d bytes %0d bad want 8 0", out_n, bad); else n_pass++;
        n_total++;
        if (stat_frames_err !== 32'd1) $display("FAIL clean_stat_err got %0d want 1", stat_frames_err); else n_pass++;
        n_total++;
        if (stat_frames_tx !== 32'd6) $display("FAIL clean_stat_tx got %0d want 6", stat_frames_tx); else n_pass++;
        n_total++;
    endtask

    task automatic test_patch_edge();
        // 5-byte frame with pos=4: only the high byte fits
        fill(5, 8'h20, 1);
        run_frame(5, 32'h1234_0005, 0, 1'b0);
        if (timed_out !== 1'b0 || out_n !== 5) $display("FAIL edge_len got %0d want 5", out_n); else n_pass++;
        n_total++;
        if (out_data[4] !== 8'h12) $display("FAIL edge_hi_byte got %h want 12", out_data[4]); else n_pass++;
        n_total++;
        if (out_data[3] !== 8'h23) $display("FAIL edge_byte3 got %h want 23", out_data[3]); else n_pass++;
        n_total++;
    endtask

    task automatic test_oob_reset();
        int bad;
        fill(60, 8'h05, 1);
        run_frame(60, 32'hBEEF_0065, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 60; i++)
            if (out_data[i] !== 8'(8'h05 + i)) bad++;
        if (timed_out !== 1'b0 || out_n !== 60 || bad !== 0) $display("FAIL oob_frame got %0d bytes %0d bad want 60 0", out_n, bad); else n_pass++;
        n_total++;
        if (stat_frames_tx !== 32'd8) $display("FAIL oob_stat_tx got %0d want 8", stat_frames_tx); else n_pass++;
        n_total++;
        // start another frame and reset it part way
        @(negedge clk);
        b.s_axis_csum_tvalid = 1'b1; b.s_axis_csum_tdata = 32'h0; b.m_axis_tready = 1'b1;
        @(negedge clk);
        b.s_axis_csum_tvalid = 1'b0;
        b.s_axis_frame_tvalid = 1'b1; b.s_axis_frame_tdata = 8'h55;
        b.s_axis_frame_tuser = 1'b0;  b.s_axis_frame_tlast = 1'b0;
        #1;
        if (b.m_axis_tvalid !== 1'b1) $display("FAIL midframe_valid got %b want 1", b.m_axis_tvalid); else n_pass++;
        n_total++;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        if (b.m_axis_tvalid !== 1'b0 || b.m_axis_tlast !== 1'b0 || b.m_axis_tdata !== 8'h00)
            $display("FAIL rst_outputs got %b/%b/%h want 0/0/00", b.m_axis_tvalid, b.m_axis_tlast, b.m_axis_tdata);
        else n_pass++;
        n_total++;
        if (b.s_axis_frame_tready !== 1'b0 || b.s_axis_csum_tready !== 1'b0)
            $display("FAIL rst_readies got %b/%b want 0/0", b.s_axis_frame_tready, b.s_axis_csum_tready);
        else n_pass++;
        n_total++;
        if (dut.state_q !== ST_IDLE) $display("FAIL rst_state got %0d want %0d", dut.state_q, ST_IDLE); else n_pass++;
        n_total++;
        if (stat_frames_tx !== 32'd0 || stat_frames_err !== 32'd0)
            $display("FAIL rst_stats got %0d/%0d want 0/0", stat_frames_tx, stat_frames_err);
        else n_pass++;
        n_total++;
        b.s_axis_frame_tvalid = 1'b0;
        // a fresh frame after reset goes through normally
        fill(4, 8'h70, 1);
        run_frame(4, 32'h0000_0000, 0, 1'b0);
        if (timed_out !== 1'b0 || out_n !== 4 || out_data[3] !== 8'h73)
            $display("FAIL post_rst_frame got %0d bytes last %h want 4 73", out_n, out_data[3]);
        else n_pass++;
        n_total++;
        if (stat_frames_tx !== 32'd1) $display("FAIL post_rst_stat_tx got %0d want 1", stat_frames_tx); else n_pass++;
        n_total++;
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_mode0();
        test_csum_wait();
        test_stall();
        test_truncated();
        test_patch_edge();
        test_oob_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
